// File: rtl/instr_encode_loader.sv
// Instruction encoder and byte-serial loader: packs instruction fields into a
// 32-bit word and writes it little-endian, one byte per cycle, into memory.
module instr_encode_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [7:0]            OPCODE,
    input  logic [2:0]            WRITEREG,
    input  logic [2:0]            READREG1,
    input  logic [2:0]            READREG2,
    input  logic [7:0]            IMMEDIATE,
    input  logic                  IMM_SEL,
    input  logic                  CLEAR,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [7:0]            MEM_WRDATA,
    output logic [31:0]           INSTRUCTION,
    output logic                  DONE,
    output logic                  FULL,
    output logic [ADDR_WIDTH-2:0] WORD_COUNT
);

    localparam int WC_W = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB0  = 3'd1,
        WB1  = 3'd2,
        WB2  = 3'd3,
        WB3  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  full_q, full_d;
    logic [WC_W-1:0]       word_count_q, word_count_d;
    logic [31:0]           instr_q, instr_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wrdata_q, mem_wrdata_d;
    logic                  done_q, done_d;
    logic                  accept_s;
    logic [31:0]           encoded_s;

    function automatic logic [31:0] encode(
        input logic [7:0] opcode,
        input logic [2:0] writereg,
        input logic [2:0] readreg1,
        input logic [2:0] readreg2,
        input logic [7:0] immediate,
        input logic       imm_sel
    );
        logic [7:0] low;
        low = imm_sel ? immediate : {5'b0, readreg2};
        return {opcode, 5'b0, writereg, 5'b0, readreg1, low};
    endfunction

    assign IN_READY  = (state_q == IDLE) & ~full_q & ~CLEAR;
    assign accept_s  = IN_VALID & IN_READY;
    assign encoded_s = encode(OPCODE, WRITEREG, READREG1, READREG2, IMMEDIATE, IMM_SEL);

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept_s ? WB0 : IDLE;
            WB0:     state_d = WB1;
            WB1:     state_d = WB2;
            WB2:     state_d = WB3;
            WB3:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointer, fill status, word counter and captured instruction
    always_comb begin
        ptr_d        = ptr_q;
        full_d       = full_q;
        word_count_d = word_count_q;
        instr_d      = accept_s ? encoded_s : instr_q;
        if ((state_q == IDLE) && CLEAR) begin
            ptr_d        = BASE;
            full_d       = 1'b0;
            word_count_d = '0;
        end else if (state_q == WB3) begin
            ptr_d        = ptr_q + ADDR_WIDTH'(4);
            full_d       = ((ptr_q + ADDR_WIDTH'(3)) == {ADDR_WIDTH{1'b1}});
            word_count_d = word_count_q + WC_W'(1);
        end else begin
            ptr_d        = ptr_q;
            full_d       = full_q;
            word_count_d = word_count_q;
        end
    end

    // Memory-side outputs are precomputed from the next state so they stay registered
    always_comb begin
        mem_write_d  = 1'b0;
        mem_addr_d   = ptr_d;
        mem_wrdata_d = mem_wrdata_q;
        done_d       = 1'b0;
        case (state_d)
            IDLE: begin
                mem_write_d = 1'b0;
                mem_addr_d  = ptr_d;
            end
            WB0: begin
                mem_write_d  = 1'b1;
                mem_addr_d   = ptr_d;
                mem_wrdata_d = instr_d[7:0];
            end
            WB1: begin
                mem_write_d  = 1'b1;
                mem_addr_d   = ptr_d + ADDR_WIDTH'(1);
                mem_wrdata_d = instr_d[15:8];
            end
            WB2: begin
                mem_write_d  = 1'b1;
                mem_addr_d   = ptr_d + ADDR_WIDTH'(2);
                mem_wrdata_d = instr_d[23:16];
            end
            WB3: begin
                mem_write_d  = 1'b1;
                mem_addr_d   = ptr_d + ADDR_WIDTH'(3);
                mem_wrdata_d = instr_d[31:24];
                done_d       = 1'b1;
            end
            default: begin
                mem_write_d = 1'b0;
                mem_addr_d  = ptr_d;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ptr_q        <= BASE;
            full_q       <= 1'b0;
            word_count_q <= '0;
            instr_q      <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= BASE;
            mem_wrdata_q <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            full_q       <= full_d;
            word_count_q <= word_count_d;
            instr_q      <= instr_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrdata_q <= mem_wrdata_d;
            done_q       <= done_d;
        end
    end

    assign MEM_WRITE   = mem_write_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WRDATA  = mem_wrdata_q;
    assign INSTRUCTION = instr_q;
    assign DONE        = done_q;
    assign FULL        = full_q;
    assign WORD_COUNT  = word_count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected byte writes are queued at
// issue time and a negedge monitor compares every strobe against the queue.
module tb_instr_encode_loader;

    localparam int AW = 4;

    logic          CLK;
    logic          RESET;
    logic          IN_VALID;
    logic          IN_READY;
    logic [7:0]    OPCODE;
    logic [2:0]    WRITEREG;
    logic [2:0]    READREG1;
    logic [2:0]    READREG2;
    logic [7:0]    IMMEDIATE;
    logic          IMM_SEL;
    logic          CLEAR;
    logic          MEM_WRITE;
    logic [AW-1:0] MEM_ADDR;
    logic [7:0]    MEM_WRDATA;
    logic [31:0]   INSTRUCTION;
    logic          DONE;
    logic          FULL;
    logic [AW-2:0] WORD_COUNT;

    instr_encode_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OPCODE(OPCODE), .WRITEREG(WRITEREG), .READREG1(READREG1),
        .READREG2(READREG2), .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL),
        .CLEAR(CLEAR), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRDATA(MEM_WRDATA), .INSTRUCTION(INSTRUCTION), .DONE(DONE),
        .FULL(FULL), .WORD_COUNT(WORD_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wr_count = 0;
    int model_ptr = 0;
    logic [12:0] sb[$];
    int done_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge CLK) begin
        if (DONE) begin
            chk("done_with_strobe", 32'(MEM_WRITE), 32'd1);
            done_cyc.push_back(cyc);
        end
        if (MEM_WRITE) begin
            wr_count++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe_addr", 32'(MEM_ADDR), 32'hFFFF_FFFF);
            end else begin
                logic [12:0] e;
                e = sb.pop_front();
                chk("wr_addr", 32'(MEM_ADDR), 32'(e[12:9]));
                chk("wr_data", 32'(MEM_WRDATA), 32'(e[8:1]));
                chk("wr_done", 32'(DONE), 32'(e[0]));
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            logic [3:0] a;
            logic [7:0] d;
            a = 4'((model_ptr + k) % 16);
            d = w[8*k +: 8];
            sb.push_back({a, d, (k == 3)});
        end
        if (nbytes == 4) model_ptr = (model_ptr + 4) % 16;
    endtask

    task automatic set_fields(input logic [7:0] op, input logic [2:0] wr, input logic [2:0] r1,
                              input logic [2:0] r2, input logic [7:0] imm, input logic sel);
        OPCODE = op; WRITEREG = wr; READREG1 = r1; READREG2 = r2; IMMEDIATE = imm; IMM_SEL = sel;
    endtask

    // Issue one word; returns #1 after the accepting edge (FSM in WB0)
    task automatic send(input logic [7:0] op, input logic [2:0] wr, input logic [2:0] r1,
                        input logic [2:0] r2, input logic [7:0] imm, input logic sel,
                        input logic [31:0] w, input int nbytes);
        int t;
        t = 0;
        @(negedge CLK);
        while (!IN_READY && t < 20) begin
            @(negedge CLK);
            t++;
        end
        chk("ready_before_send", 32'(IN_READY), 32'd1);
        set_fields(op, wr, r1, r2, imm, sel);
        IN_VALID = 1'b1;
        push_word(w, nbytes);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        set_fields(8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
        chk("instruction", INSTRUCTION, w);
        chk("ready_busy", 32'(IN_READY), 32'd0);
    endtask

    task automatic finish_word();
        repeat (4) @(posedge CLK);
        #1;
    endtask

    initial begin
        int t;
        RESET = 1'b0; IN_VALID = 1'b0; CLEAR = 1'b0;
        set_fields(8'h00, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_mem_wrdata", 32'(MEM_WRDATA), 32'd0);
        chk("rst_instruction", INSTRUCTION, 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_word_count", 32'(WORD_COUNT), 32'd0);
        RESET = 1'b1;
        #1;
        chk("ready_after_rst", 32'(IN_READY), 32'd1);

        // Word A (immediate) and word B (register source)
        send(8'h00, 3'd4, 3'd0, 3'd7, 8'h05, 1'b1, 32'h0004_0005, 4);
        finish_word();
        chk("wc_after_a", 32'(WORD_COUNT), 32'd1);
        chk("addr_idle_a", 32'(MEM_ADDR), 32'd4);
        chk("wrdata_hold_a", 32'(MEM_WRDATA), 32'h00);
        chk("mem_write_idle", 32'(MEM_WRITE), 32'd0);
        send(8'h02, 3'd3, 3'd1, 3'd2, 8'hFF, 1'b0, 32'h0203_0102, 4);
        finish_word();
        chk("wc_after_b", 32'(WORD_COUNT), 32'd2);
        chk("wrdata_hold_b", 32'(MEM_WRDATA), 32'h02);

        // Rewind, then fill the 16-byte memory with IN_VALID held
        @(negedge CLK);
        CLEAR = 1'b1;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
        model_ptr = 0;
        chk("wc_after_clear", 32'(WORD_COUNT), 32'd0);
        chk("addr_after_clear", 32'(MEM_ADDR), 32'd0);
        @(negedge CLK);
        done_cyc.delete();
        t = wr_count;
        set_fields(8'hA5, 3'd7, 3'd6, 3'd5, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) push_word(32'hA507_0605, 4);
        IN_VALID = 1'b1;
        begin
            int b;
            b = 0;
            @(posedge CLK);
            #1;
            while (!FULL && b < 40) begin
                @(posedge CLK);
                #1;
                b++;
            end
        end
        chk("full_set", 32'(FULL), 32'd1);
        chk("fill_strobes", 32'(wr_count - t), 32'd16);
        chk("fill_dones", 32'(done_cyc.size()), 32'd4);
        if (done_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("done_interval", 32'(done_cyc[i] - done_cyc[i-1]), 32'd5);
        end
        repeat (10) @(posedge CLK);
        #1;
        chk("full_ready", 32'(IN_READY), 32'd0);
        chk("full_addr", 32'(MEM_ADDR), 32'd0);
        chk("full_held", 32'(FULL), 32'd1);
        chk("full_wc", 32'(WORD_COUNT), 32'd4);
        chk("full_no_strobes", 32'(wr_count - t), 32'd16);

        // CLEAR with IN_VALID in the same cycle must not accept
        @(negedge CLK);
        set_fields(8'h3C, 3'd1, 3'd2, 3'd0, 8'h81, 1'b1);
        CLEAR = 1'b1;
        #1;
        chk("clear_blocks_ready", 32'(IN_READY), 32'd0);
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
        IN_VALID = 1'b0;
        model_ptr = 0;
        chk("clear_full", 32'(FULL), 32'd0);
        chk("clear_wc", 32'(WORD_COUNT), 32'd0);
        chk("clear_no_accept", INSTRUCTION, 32'hA507_0605);
        send(8'h3C, 3'd1, 3'd2, 3'd0, 8'h81, 1'b1, 32'h3C01_0281, 4);
        finish_word();
        chk("wc_after_d", 32'(WORD_COUNT), 32'd1);

        // CLEAR during WB2 is ignored
        send(8'h11, 3'd2, 3'd3, 3'd4, 8'hEE, 1'b0, 32'h1102_0304, 4);
        repeat (3) @(negedge CLK);
        CLEAR = 1'b1;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
        @(posedge CLK);
        #1;
        chk("clear_wb2_addr", 32'(MEM_ADDR), 32'd8);
        chk("clear_wb2_wc", 32'(WORD_COUNT), 32'd2);

        // Reset during WB1 aborts the word after two bytes
        send(8'h77, 3'd5, 3'd4, 3'd0, 8'h3E, 1'b1, 32'h7705_043E, 2);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        model_ptr = 0;
        chk("abort_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("abort_addr", 32'(MEM_ADDR), 32'd0);
        chk("abort_instruction", INSTRUCTION, 32'd0);
        chk("abort_wc", 32'(WORD_COUNT), 32'd0);
        chk("abort_ready", 32'(IN_READY), 32'd1);
        t = wr_count;
        repeat (6) @(posedge CLK);
        #1;
        chk("abort_no_strobes", 32'(wr_count - t), 32'd0);
        send(8'hC3, 3'd6, 3'd7, 3'd1, 8'h55, 1'b0, 32'hC306_0701, 4);
        finish_word();
        chk("wc_after_g", 32'(WORD_COUNT), 32'd1);
        chk("addr_after_g", 32'(MEM_ADDR), 32'd4);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the byte-address width of the target instruction memory.
REQ-002 Parameter BASE_ADDR, default 0, is the first byte address written; it SHALL be a multiple of 4.
REQ-003 CLK  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  is the synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 IN_VALID  input  1  indicates that the field inputs hold an instruction to encode.
REQ-006 IN_READY  output  1  SHALL be combinational: IDLE & !FULL & !CLEAR.
REQ-007 OPCODE  input  8  is the operation code.
REQ-008 WRITEREG  input  3  is the destination register.
REQ-009 READREG1  input  3  is the first source register.
REQ-010 READREG2  input  3  is the second source register.
REQ-011 IMMEDIATE  input  8  is the immediate value.
REQ-012 IMM_SEL  input  1  selects the low-byte source: 1 = IMMEDIATE, 0 = READREG2.
REQ-013 CLEAR  input  1  rewinds the write pointer to BASE_ADDR and clears FULL.
REQ-014 MEM_WRITE  output  1  is the byte write strobe.
REQ-015 MEM_ADDR  output  ADDR_WIDTH  is the byte address.
REQ-016 MEM_WRDATA  output  8  is the write byte.
REQ-017 INSTRUCTION  output  32  is the last accepted encoded word.
REQ-018 DONE  output  1  is a one-cycle pulse marking the final byte of a word.
REQ-019 FULL  output  1  indicates that memory is exhausted.
REQ-020 WORD_COUNT  output  ADDR_WIDTH-1  counts the words written since reset or CLEAR.

Function
REQ-021 Encoding on acceptance SHALL be:
  - [31:24] = OPCODE
  - [23:19] = 0
  - [18:16] = WRITEREG
  - [15:11] = 0
  - [10:8] = READREG1
  - [7:0] = IMM_SEL ? IMMEDIATE : {5'b0, READREG2}
REQ-022 The FSM SHALL have states IDLE, WB0, WB1, WB2 and WB3.
REQ-023 Acceptance: IN_VALID & IN_READY at edge N.
  - INSTRUCTION SHALL be registered at edge N.
  - The FSM SHALL move from IDLE to WB0 at edge N.
REQ-024 In WB0..WB3 (cycles N+1..N+4), MEM_WRITE=1.
  - MEM_ADDR SHALL be ptr, ptr+1, ptr+2, ptr+3 respectively.
  - MEM_WRDATA SHALL be INSTRUCTION[7:0], [15:8], [23:16], [31:24] respectively (little-endian).
REQ-025 DONE=1 only during WB3, where WORD_COUNT increments, ptr advances by 4 (modulo 2^ADDR_WIDTH) and the FSM returns to IDLE.
REQ-026 IN_READY SHALL be 0 during WB0..WB3; back-to-back words SHALL therefore take 5 cycles each.
REQ-027 In IDLE, MEM_WRITE=0; MEM_ADDR SHALL show ptr and MEM_WRDATA SHALL hold its last value.
REQ-028 When the WB3 byte address equals 2^ADDR_WIDTH-1, FULL SHALL be set at the end of WB3, ptr SHALL wrap to 0, and no further word is accepted.
REQ-029 When CLEAR=1 in IDLE, at the edge: ptr=BASE_ADDR, FULL=0, WORD_COUNT=0.
  - A simultaneous IN_VALID SHALL NOT be accepted, since IN_READY=0.
REQ-030 CLEAR SHALL be ignored in WB0..WB3; the word in progress completes normally.
REQ-031 Field inputs SHALL be don't-care except at the accepting edge; later changes SHALL NOT affect the word in flight.

Reset
REQ-032 With RESET=0 at an edge: FSM=IDLE, ptr=BASE_ADDR, MEM_WRITE=0, MEM_ADDR=BASE_ADDR, MEM_WRDATA=0, INSTRUCTION=0, DONE=0, FULL=0, WORD_COUNT=0.
REQ-033 Reset mid-sequence SHALL abort the word.
  - Bytes already written remain in memory.
  - No further strobes SHALL occur.
  - IN_READY=1 in the first cycle after reset deasserts.
REQ-034 Reset SHALL take priority over CLEAR and IN_VALID.

Verification
REQ-035 The bench SHALL cover the following scenarios:
  - OPCODE=0x00, WRITEREG=4, IMMEDIATE=0x05, IMM_SEL=1 -> INSTRUCTION=0x00040005; writes 05,00,04,00 to addresses 0..3; DONE with 00 at address 3; WORD_COUNT=1.
  - Then OPCODE=0x02, WRITEREG=3, READREG1=1, READREG2=2, IMM_SEL=0, IMMEDIATE=0xFF -> 0x02030102; writes 02,01,03,02 to addresses 4..7.
  - ADDR_WIDTH=4, four words held valid -> 16 strobes, one every 5 cycles; FULL=1 after the 4th DONE; IN_READY stays 0; MEM_ADDR=0.
  - From FULL, CLEAR=1 with IN_VALID=1 for one cycle -> no acceptance; FULL=0, WORD_COUNT=0; the next word is written to BASE_ADDR.
  - RESET=0 during WB1 -> MEM_WRITE=0 next cycle, MEM_ADDR=BASE_ADDR, INSTRUCTION=0; the next word restarts at BASE_ADDR.
  - CLEAR pulsed during WB2 -> the sequence completes and ptr advances by 4.
